// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: clocked Y86-64 memory stage.
// Accepts one instruction at a time over valid/ready, performs its data memory
// access after a programmable latency, and reports the result for one cycle.
//
// Handshake: a request transfers on a rising edge where valid_in and ready_out
// are both 1. ready_out is 1 only in IDLE. valid_in is ignored while busy, and
// requests are never queued. valid_out is a one-cycle pulse, with no ready
// back-pressure from downstream. valM, memdata and dmem_error are registered
// and hold until the next completion.
module mem_stage_pipe #(
    parameter int                 WIDTH    = 64,
    parameter int                 DEPTH    = 1024,
    parameter int                 LATENCY  = 2,
    parameter logic [WIDTH-1:0]   INIT_VAL = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valP,
    output logic [WIDTH-1:0] valM,
    output logic [WIDTH-1:0] memdata,
    output logic             valid_out,
    output logic             dmem_error,
    output logic [1:0]       dbg_state,
    output logic [3:0]       dbg_ifun
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(LATENCY + 1);

    localparam logic [3:0] IC_RMMOVQ = 4'd4;
    localparam logic [3:0] IC_MRMOVQ = 4'd5;
    localparam logic [3:0] IC_CALL   = 4'd8;
    localparam logic [3:0] IC_RET    = 4'd9;
    localparam logic [3:0] IC_PUSHQ  = 4'd10;
    localparam logic [3:0] IC_POPQ   = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       icode_q, icode_d;
    logic [3:0]       ifun_q, ifun_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] valm_q, valm_d;
    logic [WIDTH-1:0] memdata_q, memdata_d;
    logic             err_q, err_d;
    logic             mem_we;

    // Array contents survive reset; only power-on loads INIT_VAL.
    logic [WIDTH-1:0] mem_q [DEPTH] = '{default: INIT_VAL};

    logic             is_write;
    logic             is_read;
    logic             in_range;
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] rd_word;

    // Decode of the captured command and address; full-width range compare.
    always_comb begin
        is_write = (icode_q == IC_RMMOVQ) || (icode_q == IC_CALL) ||
                   (icode_q == IC_PUSHQ);
        is_read  = (icode_q == IC_MRMOVQ) || (icode_q == IC_RET) ||
                   (icode_q == IC_POPQ);
        in_range = (addr_q < WIDTH'(DEPTH));
        idx      = addr_q[AW-1:0];
        rd_word  = mem_q[idx];
    end

    // Next-state and result logic for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        icode_d   = icode_q;
        ifun_d    = ifun_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        valm_d    = valm_q;
        memdata_d = memdata_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    icode_d = icode;
                    ifun_d  = ifun;
                    addr_d  = (icode == IC_RET) ? valA : valE;
                    wdata_d = (icode == IC_CALL) ? valP : valA;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = S_DONE;
                    if ((is_write || is_read) && !in_range) begin
                        valm_d    = '0;
                        memdata_d = '0;
                        err_d     = 1'b1;
                    end else if (is_write) begin
                        // memdata shows the post-write word, i.e. the stored data.
                        mem_we    = 1'b1;
                        valm_d    = '0;
                        memdata_d = wdata_q;
                        err_d     = 1'b0;
                    end else if (is_read) begin
                        valm_d    = rd_word;
                        memdata_d = rd_word;
                        err_d     = 1'b0;
                    end else begin
                        valm_d    = '0;
                        memdata_d = in_range ? rd_word : '0;
                        err_d     = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and result registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            icode_q   <= '0;
            ifun_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            valm_q    <= '0;
            memdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            icode_q   <= icode_d;
            ifun_q    <= ifun_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            valm_q    <= valm_d;
            memdata_q <= memdata_d;
            err_q     <= err_d;
        end
    end

    // Data array write port; commits only on the BUSY->DONE edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

    // Outputs come straight from registers; no request input reaches them.
    always_comb begin
        ready_out  = (state_q == S_IDLE);
        valid_out  = (state_q == S_DONE);
        valM       = valm_q;
        memdata    = memdata_q;
        dmem_error = err_q;
        dbg_state  = state_q;
        dbg_ifun   = ifun_q;
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe with default parameters (LATENCY = 2).
module tb_mem_stage_pipe;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        ready_out;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [63:0] valP;
    logic [63:0] valM;
    logic [63:0] memdata;
    logic        valid_out;
    logic        dmem_error;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_ifun;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .icode      (icode),
        .ifun       (ifun),
        .valE       (valE),
        .valA       (valA),
        .valP       (valP),
        .valM       (valM),
        .memdata    (memdata),
        .valid_out  (valid_out),
        .dmem_error (dmem_error),
        .dbg_state  (dbg_state),
        .dbg_ifun   (dbg_ifun)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request, wait for its completion pulse, check the latency.
    task automatic do_op(input string tag, input logic [3:0] ic, input logic [63:0] e,
                         input logic [63:0] a, input logic [63:0] p);
        int n;
        @(negedge clk);
        n = 0;
        while (!ready_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 64'(ready_out), 64'd1);
        icode    = ic;
        ifun     = 4'h3;
        valE     = e;
        valA     = a;
        valP     = p;
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (valid_out) break;
        end
        // negedges after edges k, k+1 are BUSY; after k+2 is DONE
        check({tag, "_latency"}, 64'(n), 64'd3);
    endtask

    int pulses;

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        icode    = '0;
        ifun     = '0;
        valE     = '0;
        valA     = '0;
        valP     = '0;
        #3;
        check("rst_ready", 64'(ready_out), 64'd1);
        check("rst_vout", 64'(valid_out), 64'd0);
        check("rst_valM", valM, 64'd0);
        check("rst_memdata", memdata, 64'd0);
        check("rst_err", 64'(dmem_error), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // write then read back
        do_op("rmmovq", 4'd4, 64'd5, 64'h1234, 64'd0);
        check("rmmovq_memdata", memdata, 64'h1234);
        check("rmmovq_err", 64'(dmem_error), 64'd0);
        do_op("mrmovq", 4'd5, 64'd5, 64'd0, 64'd0);
        check("mrmovq_valM", valM, 64'h1234);
        check("mrmovq_memdata", memdata, 64'h1234);

        // call / ret / popq of untouched word
        do_op("call", 4'd8, 64'd100, 64'd55, 64'h40);
        check("call_memdata", memdata, 64'h40);
        do_op("ret", 4'd9, 64'd3, 64'd100, 64'd0);
        check("ret_valM", valM, 64'h40);
        do_op("popq", 4'd11, 64'd7, 64'd0, 64'd0);
        check("popq_valM", valM, 64'd7);

        // hold of results after completion
        repeat (3) @(negedge clk);
        check("hold_valM", valM, 64'd7);
        check("hold_vout", 64'(valid_out), 64'd0);

        // range errors, including high address bits that alias word 5
        do_op("push_oor", 4'd10, 64'd1024, 64'd9, 64'd0);
        check("push_oor_err", 64'(dmem_error), 64'd1);
        check("push_oor_valM", valM, 64'd0);
        check("push_oor_memdata", memdata, 64'd0);
        do_op("push_hi", 4'd10, 64'h1_0000_0005, 64'd9, 64'd0);
        check("push_hi_err", 64'(dmem_error), 64'd1);
        do_op("rd5", 4'd5, 64'd5, 64'd0, 64'd0);
        check("rd5_valM", valM, 64'h1234);
        check("rd5_err", 64'(dmem_error), 64'd0);
        do_op("rd1023", 4'd5, 64'd1023, 64'd0, 64'd0);
        check("rd1023_valM", valM, 64'd7);
        do_op("ret_oor", 4'd9, 64'd5, 64'd2000, 64'd0);
        check("ret_oor_err", 64'(dmem_error), 64'd1);
        check("ret_oor_valM", valM, 64'd0);

        // handshake with valid_in held high and a new request every cycle
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            icode    = 4'd4;
            valE     = 64'(200 + i);
            valA     = 64'(256 + i);
            valid_in = 1'b1;
            check("hs_ready", 64'(ready_out), 64'((i % 4) == 0));
            check("hs_vout", 64'(valid_out), 64'((i % 4) == 3));
            if ((i % 4) == 3) check("hs_memdata", memdata, 64'(256 + i - 3));
            @(negedge clk);
        end
        valid_in = 1'b0;
        do_op("hs_rd200", 4'd5, 64'd200, 64'd0, 64'd0);
        check("hs_rd200_valM", valM, 64'h100);
        do_op("hs_rd201", 4'd5, 64'd201, 64'd0, 64'd0);
        check("hs_rd201_valM", valM, 64'd7);

        // reset while a write is in flight
        @(negedge clk);
        icode    = 4'd4;
        valE     = 64'd3;
        valA     = 64'hAA;
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 64'(ready_out), 64'd1);
        check("mid_rst_valM", valM, 64'd0);
        check("mid_rst_memdata", memdata, 64'd0);
        check("mid_rst_vout", 64'(valid_out), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid_out) pulses++;
        end
        check("mid_rst_pulses", 64'(pulses), 64'd0);
        check("mid_rst_ready2", 64'(ready_out), 64'd1);
        do_op("rd3", 4'd5, 64'd3, 64'd0, 64'd0);
        check("rd3_valM", valM, 64'd7);

        // non-memory icode
        do_op("nop6", 4'd6, 64'd2, 64'd0, 64'd0);
        check("nop6_valM", valM, 64'd0);
        check("nop6_err", 64'(dmem_error), 64'd0);
        check("nop6_memdata", memdata, 64'd7);
        do_op("nop6_oor", 4'd6, 64'd5000, 64'd0, 64'd0);
        check("nop6_oor_err", 64'(dmem_error), 64'd0);
        check("nop6_oor_memdata", memdata, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
